i2s_tx_clkgen: RTL and testbench

- Downstream consumer of the audio PLL's 18.432 MHz output clock and its locked flag.
- Qualifies PLL lock, then derives the I2S bit clock and word clock (64 bit clocks per frame, 48 kHz at 18.432 MHz) and serializes one stereo sample per frame to the codec DAC pin.
- Accepts samples from the Nios-side audio path through a valid/ready handshake backed by a single-entry holding register.

---
 rtl/i2s_tx_clkgen.sv | 189 ++++++++++++++++++
 tb/tb_i2s_tx_clkgen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_clkgen.sv
// i2s_tx_clkgen
//   Qualifies the audio PLL lock flag, then generates the I2S bit clock and
//   word clock (64 bit clocks per frame) from clk and shifts one stereo
//   sample pair per frame out on dacdat. Samples arrive through a
//   valid/ready handshake into a single-entry holding register.
//
// Ports
//   clk        audio master clock
//   rst_n      asynchronous active-low reset
//   locked_in  PLL locked flag, asynchronous to clk
//   s_valid    sample pair valid
//   s_ready    holding register empty and block running
//   s_left     left sample, two's complement
//   s_right    right sample, two's complement
//   bclk       I2S bit clock
//   lrclk      I2S word select (0 = left, 1 = right)
//   dacdat     I2S serial data
//   running    lock qualified, clocks active
//   underrun   one-clk pulse when a frame starts with no sample held
module i2s_tx_clkgen #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned BCLK_HALF = 3,
    parameter int unsigned LOCK_WAIT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked_in,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              bclk,
    output logic              lrclk,
    output logic              dacdat,
    output logic              running,
    output logic              underrun
);

    localparam int unsigned LCNT_W = $clog2(LOCK_WAIT + 1);
    localparam int unsigned PH_W   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_WAIT - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BCLK_HALF - 1);

    typedef enum logic {
        WAIT_LOCK,
        RUN
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, locked_s_q;
    logic [LCNT_W-1:0]   lockcnt_q, lockcnt_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                dac_q, dac_d;
    logic                ur_q, ur_d;
    logic [5:0]          bitcnt_q, bitcnt_d;
    logic                hold_full_q, hold_full_d;
    logic [DATA_W-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_W-1:0]   frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic [DATA_W-1:0]   chan;
    logic                accept;

    assign running  = (state_q == RUN);
    assign s_ready  = running && !hold_full_q;
    assign accept   = s_valid && s_ready;
    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign dacdat   = dac_q;
    assign underrun = ur_q;

    // Lock counter saturates at LOCK_LAST so a long lock never wraps it.
    always_comb begin
        lockcnt_d = lockcnt_q;
        if (!locked_s_q) begin
            lockcnt_d = '0;
        end else if (lockcnt_q != LOCK_LAST) begin
            lockcnt_d = lockcnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        dac_d       = dac_q;
        ur_d        = 1'b0;
        bitcnt_d    = bitcnt_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        frame_l_d   = frame_l_q;
        frame_r_d   = frame_r_q;
        chan        = '0;

        case (state_q)
            WAIT_LOCK: if (locked_s_q && lockcnt_q == LOCK_LAST) state_d = RUN;
            RUN:       if (!locked_s_q) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase

        if (state_q == RUN && locked_s_q) begin
            // Accept only happens with the holding register empty, so it
            // never collides with the frame load emptying it.
            if (accept) begin
                hold_full_d = 1'b1;
                hold_l_d    = s_left;
                hold_r_d    = s_right;
            end
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                bclk_d  = !bclk_q;
                if (bclk_q) begin
                    bitcnt_d = bitcnt_q + 6'd1;
                    if (bitcnt_q == 6'd63) begin
                        if (hold_full_q) begin
                            frame_l_d   = hold_l_q;
                            frame_r_d   = hold_r_q;
                            hold_full_d = 1'b0;
                        end else begin
                            frame_l_d = '0;
                            frame_r_d = '0;
                            ur_d      = 1'b1;
                        end
                    end
                    lrclk_d = bitcnt_d[5];
                    // Slot 0 of each channel is the one-bit delay, so using
                    // the pre-load frame register on the load edge is safe.
                    chan  = bitcnt_d[5] ? frame_r_q : frame_l_q;
                    dac_d = 1'b0;
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (bitcnt_d[4:0] == 5'(DATA_W - i)) dac_d = chan[i];
                    end
                end
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end else begin
            phase_d     = '0;
            bclk_d      = 1'b0;
            lrclk_d     = 1'b0;
            dac_d       = 1'b0;
            bitcnt_d    = 6'd63;
            hold_full_d = 1'b0;
            hold_l_d    = '0;
            hold_r_d    = '0;
            frame_l_d   = '0;
            frame_r_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            sync1_q     <= 1'b0;
            locked_s_q  <= 1'b0;
            lockcnt_q   <= '0;
            phase_q     <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            dac_q       <= 1'b0;
            ur_q        <= 1'b0;
            bitcnt_q    <= 6'd63;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            frame_l_q   <= '0;
            frame_r_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= locked_in;
            locked_s_q  <= sync1_q;
            lockcnt_q   <= lockcnt_d;
            phase_q     <= phase_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            dac_q       <= dac_d;
            ur_q        <= ur_d;
            bitcnt_q    <= bitcnt_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            frame_l_q   <= frame_l_d;
            frame_r_q   <= frame_r_d;
        end
    end

endmodule

// File: tb/tb_i2s_tx_clkgen.sv
// tb_i2s_tx_clkgen
//   Directed bench for i2s_tx_clkgen with DATA_W=24, BCLK_HALF=3,
//   LOCK_WAIT=16. Frame length is 384 clk; frame loads fall 6 clk after
//   RUN entry and every 384 clk after that.
module tb_i2s_tx_clkgen;

    logic        clk;
    logic        rst_n;
    logic        locked_in;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_left;
    logic [23:0] s_right;
    logic        bclk;
    logic        lrclk;
    logic        dacdat;
    logic        running;
    logic        underrun;

    i2s_tx_clkgen #(
        .DATA_W   (24),
        .BCLK_HALF(3),
        .LOCK_WAIT(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .locked_in(locked_in),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .dacdat   (dacdat),
        .running  (running),
        .underrun (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acc_total = 0;
    int ur_total  = 0;
    int k        = 0;
    bit stream   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] mk_l(input int n);
        return 24'(32'h00A5_0000 + n);
    endfunction

    function automatic logic [23:0] mk_r(input int n);
        return 24'(32'h005A_0000 + n);
    endfunction

    // Expected dacdat per slot n (n = bit counter after the falling edge).
    function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        logic [23:0] w;
        int p;
        f = '0;
        for (int n = 0; n < 64; n++) begin
            p = n % 32;
            w = (n >= 32) ? r : l;
            if (p >= 1 && p <= 24) f[n] = w[24-p];
        end
        return f;
    endfunction

    task automatic tick();
        logic acc;
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            acc_total++;
            if (stream) begin
                k++;
                s_left  = mk_l(k);
                s_right = mk_r(k);
            end
        end
        if (underrun) ur_total++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Samples dacdat/lrclk on each bclk falling edge of the frame whose load edge is L.
    task automatic capture(input int L, output logic [63:0] d, output logic [63:0] lr,
                           output logic ur0);
        d  = '0;
        lr = '0;
        ur0 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            run_to(L + 6 * i);
            d[i]  = dacdat;
            lr[i] = lrclk;
            if (i == 0) ur0 = underrun;
        end
    endtask

    localparam logic [63:0] LR_PAT = 64'hFFFF_FFFF_0000_0000;

    initial begin
        int E, D, R2, L;
        int bad, bad_duty, bad_align, bad_ur, bad_dat, ur_b;
        int last_tog, lr_r1, lr_r2, lr_f1;
        logic prev_b, prev_lr, ur0;
        logic [63:0] d, lr;

        rst_n = 1'b1;
        locked_in = 1'b0;
        s_valid = 1'b0;
        s_left  = '0;
        s_right = '0;
        #2 rst_n = 1'b0;
        #20;
        check_eq("reset_outputs", 64'({bclk, lrclk, dacdat, running, s_ready, underrun}), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;

        // Lock qualification: locked_in rises after edge 10, running at edge 28.
        bad = 0;
        while (cyc < 27) begin
            if (cyc == 10) locked_in = 1'b1;
            tick();
            if ({bclk, lrclk, dacdat, running, s_ready, underrun} != 6'b0) bad++;
        end
        check_eq("pre_run_quiet", 64'(bad), 64'h0);
        check_eq("running_at_27", 64'(running), 64'h0);
        tick();
        check_eq("running_at_28", 64'(running), 64'h1);
        check_eq("ready_at_28", 64'(s_ready), 64'h1);
        E = cyc;

        // Free run without samples for three frames.
        bad_duty = 0; bad_align = 0; bad_ur = 0; bad_dat = 0; ur_b = 0;
        last_tog = E; lr_r1 = -1; lr_r2 = -1; lr_f1 = -1;
        prev_b = bclk; prev_lr = lrclk;
        while (cyc < E + 1100) begin
            tick();
            if (bclk != prev_b) begin
                if (cyc - last_tog != 3) bad_duty++;
                last_tog = cyc;
            end
            if (lrclk != prev_lr) begin
                if (!(prev_b && !bclk)) bad_align++;
                if (lrclk) begin
                    if (lr_r1 < 0) lr_r1 = cyc;
                    else if (lr_r2 < 0) lr_r2 = cyc;
                end else if (lr_f1 < 0) begin
                    lr_f1 = cyc;
                end
            end
            if (underrun) begin
                ur_b++;
                if ((cyc - E - 6) % 384 != 0) bad_ur++;
            end
            if (dacdat) bad_dat++;
            prev_b = bclk;
            prev_lr = lrclk;
        end
        check_eq("bclk_half_period", 64'(bad_duty), 64'h0);
        check_eq("lrclk_on_bclk_fall", 64'(bad_align), 64'h0);
        check_eq("lrclk_first_rise", 64'(lr_r1 - E), 64'd198);
        check_eq("lrclk_high_len", 64'(lr_f1 - lr_r1), 64'd192);
        check_eq("lrclk_period", 64'(lr_r2 - lr_r1), 64'd384);
        check_eq("underrun_count", 64'(ur_b), 64'd3);
        check_eq("underrun_on_load", 64'(bad_ur), 64'h0);
        check_eq("idle_dacdat_zero", 64'(bad_dat), 64'h0);

        // Single sample pair 0xABCDEF / 0x123456.
        s_valid = 1'b1;
        s_left  = 24'hABCDEF;
        s_right = 24'h123456;
        tick();
        s_valid = 1'b0;
        check_eq("accept_drops_ready", 64'(s_ready), 64'h0);
        L = E + 1158;
        capture(L, d, lr, ur0);
        check_eq("loaded_no_underrun", 64'(ur0), 64'h0);
        check_eq("frame_abcdef_123456", d, exp_frame(24'hABCDEF, 24'h123456));
        check_eq("frame_lrclk", lr, LR_PAT);
        check_eq("ready_after_load", 64'(s_ready), 64'h1);
        run_to(L + 384);
        check_eq("empty_next_underrun", 64'(underrun), 64'h1);

        // Streaming: s_valid held high with incrementing data.
        ur_total = 0;
        acc_total = 0;
        k = 0;
        s_left  = mk_l(0);
        s_right = mk_r(0);
        s_valid = 1'b1;
        stream  = 1'b1;
        for (int f = 0; f < 3; f++) begin
            capture(E + 1926 + 384 * f, d, lr, ur0);
            check_eq($sformatf("stream_frame%0d", f), d, exp_frame(mk_l(f), mk_r(f)));
        end
        run_to(E + 3080);
        stream  = 1'b0;
        s_valid = 1'b0;
        check_eq("stream_accepts", 64'(acc_total), 64'd5);
        check_eq("stream_no_underrun", 64'(ur_total), 64'h0);
        check_eq("stream_hold_full", 64'(s_ready), 64'h0);

        // Lock loss at bit 40 of the frame loaded at E+3078.
        D = E + 3318;
        run_to(D);
        locked_in = 1'b0;
        run_to(D + 2);
        check_eq("running_before_drop", 64'(running), 64'h1);
        run_to(D + 3);
        check_eq("lockloss_outputs", 64'({bclk, lrclk, dacdat, running, s_ready, underrun}), 64'h0);
        run_to(D + 20);
        locked_in = 1'b1;
        R2 = D + 38;
        run_to(R2 - 1);
        check_eq("relock_running_early", 64'(running), 64'h0);
        run_to(R2);
        check_eq("relock_running", 64'(running), 64'h1);
        check_eq("relock_hold_cleared", 64'(s_ready), 64'h1);
        capture(R2 + 6, d, lr, ur0);
        check_eq("relock_underrun", 64'(ur0), 64'h1);
        check_eq("relock_frame_zero", d, 64'h0);
        check_eq("relock_left_first", lr, LR_PAT);

        // Asynchronous reset mid-frame.
        run_to(R2 + 406);
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs", 64'({bclk, lrclk, dacdat, running, s_ready, underrun}), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
